// File: rtl/valid_streak_monitor.sv
// Watches an upstream valid flag and latches a sticky failure after HOLD consecutive invalid samples.
// Optional glitch counter output enabled by defining VALID_STREAK_MONITOR_GLITCH_EN.
//
// state | meaning
// WATCH | valid seen, no invalid streak in progress
// PEND  | invalid streak in progress, shorter than HOLD
// FAIL  | failure latched, waiting for clr
module valid_streak_monitor #(
  parameter int WIDTH    = 12,
  parameter int TS_WIDTH = 16,
  parameter int HOLD     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic [WIDTH-1:0]    count_in,
  input  logic                clr,
  output logic                fail,
  output logic [WIDTH-1:0]    fail_count,
  output logic [TS_WIDTH-1:0] fail_time,
  output logic                busy
`ifdef VALID_STREAK_MONITOR_GLITCH_EN
  ,
  output logic [7:0]          glitch_cnt
`endif
);

  localparam int SW = $clog2(HOLD + 1);
  localparam logic [SW-1:0] STREAK_LAST = SW'(HOLD - 1);

  typedef enum logic [1:0] {
    WATCH = 2'd0,
    PEND  = 2'd1,
    FAIL  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [SW-1:0]       streak;
  logic [WIDTH-1:0]    cand_count;
  logic [TS_WIDTH-1:0] cand_time;
  logic [TS_WIDTH-1:0] ts;
  logic                streak_hit;

  assign streak_hit = (streak == STREAK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WATCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WATCH: begin
        if (!valid_in) begin
          state_nxt = (HOLD == 1) ? FAIL : PEND;
        end
      end
      PEND: begin
        if (valid_in) begin
          state_nxt = WATCH;
        end else if (streak_hit) begin
          state_nxt = FAIL;
        end
      end
      FAIL: begin
        if (clr) begin
          state_nxt = WATCH;
        end
      end
      default: state_nxt = WATCH;
    endcase
  end

  always_comb begin
    fail = (state == FAIL);
    busy = (state == PEND);
  end

  // The candidate captures the first invalid sample so the latched values point at the streak start.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts         <= '0;
      streak     <= '0;
      cand_count <= '0;
      cand_time  <= '0;
      fail_count <= '0;
      fail_time  <= '0;
    end else begin
      if (ts != '1) begin
        ts <= ts + TS_WIDTH'(1);
      end
      case (state)
        WATCH: begin
          if (!valid_in) begin
            if (HOLD == 1) begin
              fail_count <= count_in;
              fail_time  <= ts;
            end else begin
              streak     <= SW'(1);
              cand_count <= count_in;
              cand_time  <= ts;
            end
          end
        end
        PEND: begin
          if (valid_in) begin
            streak <= '0;
          end else if (streak_hit) begin
            fail_count <= cand_count;
            fail_time  <= cand_time;
            streak     <= '0;
          end else begin
            streak <= streak + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef VALID_STREAK_MONITOR_GLITCH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if ((state == PEND) && valid_in && (glitch_cnt != 8'hFF)) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_valid_streak_monitor.sv
// Randomized and directed bench for valid_streak_monitor, comparing two configurations
// (HOLD=4/TS_WIDTH=16 and HOLD=1/TS_WIDTH=4) against a run-length model every cycle.
module tb_valid_streak_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [11:0] count_in = '0;
  logic        clr = 1'b0;

  logic        fail1, busy1, fail2, busy2;
  logic [11:0] fail_count1, fail_count2;
  logic [15:0] fail_time1;
  logic [3:0]  fail_time2;
`ifdef VALID_STREAK_MONITOR_GLITCH_EN
  logic [7:0]  glitch1, glitch2;
`endif

  int cmp_n = 0;
  int err_n = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  valid_streak_monitor #(.WIDTH(12), .TS_WIDTH(16), .HOLD(4)) dut1 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .count_in(count_in), .clr(clr),
    .fail(fail1), .fail_count(fail_count1), .fail_time(fail_time1), .busy(busy1)
`ifdef VALID_STREAK_MONITOR_GLITCH_EN
    , .glitch_cnt(glitch1)
`endif
  );

  valid_streak_monitor #(.WIDTH(12), .TS_WIDTH(4), .HOLD(1)) dut2 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .count_in(count_in), .clr(clr),
    .fail(fail2), .fail_count(fail_count2), .fail_time(fail_time2), .busy(busy2)
`ifdef VALID_STREAK_MONITOR_GLITCH_EN
    , .glitch_cnt(glitch2)
`endif
  );

  // Model: length of the current run of invalid samples plus the first sample of that run.
  typedef struct {
    bit fl;
    int run;
    int cc;
    int ct;
    int fc;
    int ft;
    int ts;
    int gl;
  } ms_t;

  ms_t m1 = '{default: 0};
  ms_t m2 = '{default: 0};

  function automatic ms_t mstep(ms_t s, bit r, bit v, int cnt, bit cl, int hold, int tsmax);
    ms_t n;
    n = s;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    n.ts = (s.ts == tsmax) ? s.ts : s.ts + 1;
    if (s.fl) begin
      if (cl) n.fl = 1'b0;
    end else if (v) begin
      if (s.run > 0 && s.gl < 255) n.gl = s.gl + 1;
      n.run = 0;
    end else begin
      if (s.run == 0) begin
        n.cc = cnt;
        n.ct = s.ts;
      end
      if (s.run + 1 == hold) begin
        n.fl  = 1'b1;
        n.fc  = (s.run == 0) ? cnt : s.cc;
        n.ft  = (s.run == 0) ? s.ts : s.ct;
        n.run = 0;
      end else begin
        n.run = s.run + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m1 = mstep(m1, rst, valid_in, int'(count_in), clr, 4, 65535);
    m2 = mstep(m2, rst, valid_in, int'(count_in), clr, 1, 15);
  end

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    cmp_n++;
    if (act !== 32'(exp)) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("d1.fail", 32'(fail1), int'(m1.fl));
      chk("d1.busy", 32'(busy1), (m1.run > 0) ? 1 : 0);
      chk("d1.fail_count", 32'(fail_count1), m1.fc);
      chk("d1.fail_time", 32'(fail_time1), m1.ft);
      chk("d2.fail", 32'(fail2), int'(m2.fl));
      chk("d2.busy", 32'(busy2), (m2.run > 0) ? 1 : 0);
      chk("d2.fail_count", 32'(fail_count2), m2.fc);
      chk("d2.fail_time", 32'(fail_time2), m2.ft);
`ifdef VALID_STREAK_MONITOR_GLITCH_EN
      chk("d1.glitch", 32'(glitch1), m1.gl);
      chk("d2.glitch", 32'(glitch2), m2.gl);
`endif
    end
  end

  task automatic drive(input bit r, input bit v, input logic [11:0] c, input bit cl);
    rst = r;
    valid_in = v;
    count_in = c;
    clr = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    drive(1'b1, 1'b0, 12'hABC, 1'b0);
    drive(1'b1, 1'b0, 12'hABC, 1'b0);
    chk("rst.fail", 32'(fail1), 0);
    chk("rst.fail_count", 32'(fail_count1), 0);
    chk("rst.fail_time", 32'(fail_time1), 0);
    chk("rst.busy", 32'(busy1), 0);
    chk_en = 1'b1;

    // Basic failure: lows at ts=10..13
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 12'h001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 12'hFFF, 1'b0);
      if (i < 3) chk("basic.busy", 32'(busy1), 1);
    end
    chk("basic.fail", 32'(fail1), 1);
    chk("basic.fail_count", 32'(fail_count1), 12'hFFF);
    chk("basic.fail_time", 32'(fail_time1), 10);
    chk("hold1.fail_time", 32'(fail_time2), 10);
    for (int i = 0; i < 20; i++) drive(1'b0, i[0], 12'($urandom), 1'b0);
    chk("basic.hold", 32'(fail1), 1);

    // Acknowledge at ts=34 with valid low; that sample must not start a streak
    drive(1'b0, 1'b0, 12'h777, 1'b1);
    chk("ack.fail", 32'(fail1), 0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 12'h321, 1'b0);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 12'h321, 1'b0);
    chk("ack.nocount", 32'(fail1), 0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 12'h123, 1'b0);
    chk("ack.fail2", 32'(fail1), 1);
    chk("ack.fail_count", 32'(fail_count1), 12'h123);
    chk("ack.fail_time", 32'(fail_time1), 40);

    // Glitch streaks
    drive(1'b1, 1'b1, 12'h000, 1'b0);
    for (int r = 0; r < 300; r++) begin
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 12'h0AA, 1'b0);
      drive(1'b0, 1'b1, 12'h0AA, 1'b0);
      if (r == 0) begin
        chk("glitch.fail", 32'(fail1), 0);
        chk("glitch.busy", 32'(busy1), 0);
`ifdef VALID_STREAK_MONITOR_GLITCH_EN
        chk("glitch.one", 32'(glitch1), 1);
`endif
      end
    end
`ifdef VALID_STREAK_MONITOR_GLITCH_EN
    chk("glitch.sat", 32'(glitch1), 255);
`endif

    // Reset mid-streak
    drive(1'b1, 1'b1, 12'h000, 1'b0);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 12'h0BB, 1'b0);
    drive(1'b1, 1'b0, 12'h0BB, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 12'h0CC, 1'b0);
      chk("midrst.nofail", 32'(fail1), 0);
    end
    drive(1'b0, 1'b0, 12'h0CC, 1'b0);
    chk("midrst.fail", 32'(fail1), 1);

    // Timestamp saturation, HOLD=1, clr ignored outside FAIL
    drive(1'b1, 1'b1, 12'h000, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 12'h000, (i == 5 || i == 12));
    chk("sat.nofail", 32'(fail2), 0);
    drive(1'b0, 1'b0, 12'h055, 1'b0);
    chk("sat.fail", 32'(fail2), 1);
    chk("sat.fail_time", 32'(fail_time2), 15);
    chk("sat.fail_count", 32'(fail_count2), 12'h055);
    chk("pendclr.busy", 32'(busy1), 1);
    drive(1'b0, 1'b0, 12'h066, 1'b1);
    drive(1'b0, 1'b0, 12'h066, 1'b0);
    drive(1'b0, 1'b0, 12'h066, 1'b0);
    chk("pendclr.fail", 32'(fail1), 1);
    chk("pendclr.fail_time", 32'(fail_time1), 20);
    chk("pendclr.fail_count", 32'(fail_count1), 12'h055);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 45, 12'($urandom),
            $urandom_range(0, 99) < 15);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
